// File: rtl/half_adder_axis_pkg.sv
// rtl/half_adder_axis_pkg.sv - shared types and constants for the half-adder stream wrapper
package half_adder_axis_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int OPERAND_W = 2;
    localparam int RESULT_W  = 2;

    localparam int IDX_A     = 0;
    localparam int IDX_B     = 1;
    localparam int IDX_SUM   = 0;
    localparam int IDX_CARRY = 1;

endpackage

// File: rtl/half_adder_core.sv
// rtl/half_adder_core.sv - combinational half adder
module half_adder_core (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder_axis_master_slave.sv
// rtl/half_adder_axis_master_slave.sv - single-beat stream wrapper around a half adder
// Optional HALF_ADDER_AXIS_FULL_THROUGHPUT_EN: accept a new pair in the cycle the result drains.
module half_adder_axis_master_slave
    import half_adder_axis_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tvalid,
    input  logic [OPERAND_W-1:0] s_tdata,
    output logic                s_tready,
    output logic                m_tvalid,
    output logic [RESULT_W-1:0] m_tdata,
    input  logic                m_tready
);

    state_t              state;
    logic                sum;
    logic                carry;
    logic [RESULT_W-1:0] result;

    half_adder_core u_core (
        .a     (s_tdata[IDX_A]),
        .b     (s_tdata[IDX_B]),
        .sum   (sum),
        .carry (carry)
    );

    always_comb begin
        result            = '0;
        result[IDX_SUM]   = sum;
        result[IDX_CARRY] = carry;
    end

`ifdef HALF_ADDER_AXIS_FULL_THROUGHPUT_EN
    // HOLD tracks m_tvalid exactly, so the slot is free when empty or draining.
    assign s_tready = (state == ST_IDLE) || m_tready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else if (s_tvalid && s_tready) begin
            state    <= ST_HOLD;
            m_tvalid <= 1'b1;
            m_tdata  <= result;
        end else if (m_tvalid && m_tready) begin
            state    <= ST_IDLE;
            m_tvalid <= 1'b0;
        end
    end
`else
    logic s_tready_q;

    assign s_tready = s_tready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            s_tready_q <= 1'b1;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_tvalid) begin
                        state      <= ST_HOLD;
                        s_tready_q <= 1'b0;
                        m_tvalid   <= 1'b1;
                        m_tdata    <= result;
                    end
                end
                ST_HOLD: begin
                    // m_tdata is left untouched so it survives into IDLE
                    if (m_tready) begin
                        state      <= ST_IDLE;
                        s_tready_q <= 1'b1;
                        m_tvalid   <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    s_tready_q <= 1'b1;
                    m_tvalid   <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_half_adder_axis_master_slave.sv
// tb/tb_half_adder_axis_master_slave.sv - scoreboard bench for half_adder_axis_master_slave
module tb_half_adder_axis_master_slave;

    logic       clk;
    logic       reset;
    logic       s_tvalid;
    logic [1:0] s_tdata;
    logic       s_tready;
    logic       m_tvalid;
    logic [1:0] m_tdata;
    logic       m_tready;

    logic [1:0] sb[$];
    int         checks;
    int         errors;

    half_adder_axis_master_slave dut (
        .clk      (clk),
        .reset    (reset),
        .s_tvalid (s_tvalid),
        .s_tdata  (s_tdata),
        .s_tready (s_tready),
        .m_tvalid (m_tvalid),
        .m_tdata  (m_tdata),
        .m_tready (m_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat for a single cycle and record its hand-computed result.
    task automatic send(input logic [1:0] data, input logic [1:0] expected);
        s_tdata  = data;
        s_tvalid = 1'b1;
        sb.push_back(expected);
        tick();
        s_tvalid = 1'b0;
    endtask

    // Monitor: a transfer is committed at the next rising edge when both are high mid-cycle.
    always @(negedge clk) begin
        if (reset && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none at %0t", m_tdata, $time);
            end else begin
                check("sb_data", m_tdata, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] tt_in  [4];
    logic [1:0] tt_out [4];

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 2'b00;
        m_tready = 1'b0;
        tt_in  = '{2'b00, 2'b01, 2'b10, 2'b11};
        tt_out = '{2'b00, 2'b01, 2'b01, 2'b10};

        repeat (2) tick();
        check("rst_s_tready", s_tready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        reset = 1'b1;
        tick();

        // Truth table with latency checks
        for (int i = 0; i < 4; i++) begin
            send(tt_in[i], tt_out[i]);
            check("lat_m_tvalid", m_tvalid, 1);
            check("lat_s_tready", s_tready, 0);
            tick();
            check("hold_m_tvalid", m_tvalid, 1);
            m_tready = 1'b1;
            tick();
            check("xfer_m_tvalid", m_tvalid, 0);
            check("xfer_s_tready", s_tready, 1);
            m_tready = 1'b0;
            check("keep_m_tdata", m_tdata, tt_out[i]);
            tick();
        end

        // Backpressure
        send(2'b11, 2'b10);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_m_tvalid", m_tvalid, 1);
            check("bp_m_tdata", m_tdata, 2'b10);
            check("bp_s_tready", s_tready, 0);
        end
        m_tready = 1'b1;
        tick();
        check("bp_done_m_tvalid", m_tvalid, 0);
        check("bp_done_s_tready", s_tready, 1);
        m_tready = 1'b0;
        tick();

        // Input ignored while holding
        send(2'b01, 2'b01);
        s_tdata  = 2'b11;
        s_tvalid = 1'b1;
        repeat (3) begin
            tick();
            check("ign_m_tdata", m_tdata, 2'b01);
            check("ign_m_tvalid", m_tvalid, 1);
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (4) tick();
        check("ign_after_m_tvalid", m_tvalid, 0);
        check("ign_after_m_tdata", m_tdata, 2'b01);
        m_tready = 1'b0;
        tick();

        // Reset while holding drops the pending result
        send(2'b11, 2'b10);
        check("rh_m_tvalid", m_tvalid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rh_rst_m_tvalid", m_tvalid, 0);
        check("rh_rst_s_tready", s_tready, 1);
        check("rh_rst_m_tdata", m_tdata, 0);
        sb.delete();
        tick();
        reset = 1'b1;
        tick();

`ifdef HALF_ADDER_AXIS_FULL_THROUGHPUT_EN
        // Back-to-back stream with the sink always ready
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_tdata  = tt_in[i];
            s_tvalid = 1'b1;
            sb.push_back(tt_out[i]);
            tick();
            check("ft_m_tvalid", m_tvalid, 1);
            check("ft_m_tdata", m_tdata, tt_out[i]);
        end
        s_tvalid = 1'b0;
        tick();
        check("ft_end_m_tvalid", m_tvalid, 0);
        m_tready = 1'b0;
        tick();
`endif

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
